// File: rtl/player_shot_if.sv
// Player shot bus: keys, cannon and invader geometry in,
// shot geometry, hit strobe and score out.
interface player_shot_if #(
  parameter int N_INV = 10
);
  logic [7:0]         keycode;
  logic [9:0]         PlayerX;
  logic [9:0]         PlayerY;
  logic [9:0]         InvaderS;
  logic [10*N_INV-1:0] InvaderX_all;
  logic [10*N_INV-1:0] InvaderY_all;
  logic [N_INV-1:0]   InvaderOn_all;
  logic [9:0]         ShotX;
  logic [9:0]         ShotY;
  logic [9:0]         ShotW;
  logic [9:0]         ShotH;
  logic               ShotActive;
  logic [N_INV-1:0]   Collision;
  logic [7:0]         HitCount;

  modport master (
    output keycode, PlayerX, PlayerY, InvaderS,
    output InvaderX_all, InvaderY_all, InvaderOn_all,
    input  ShotX, ShotY, ShotW, ShotH,
    input  ShotActive, Collision, HitCount
  );

  modport slave (
    input  keycode, PlayerX, PlayerY, InvaderS,
    input  InvaderX_all, InvaderY_all, InvaderOn_all,
    output ShotX, ShotY, ShotW, ShotH,
    output ShotActive, Collision, HitCount
  );
endinterface

// File: rtl/player_shot.sv
// Player laser: fire, rise each frame, box-test every invader,
// strobe one-hot Collision to the lowest-index hit.
module player_shot #(
  parameter int N_INV       = 10,
  parameter int SHOT_STEP   = 8,
  parameter int SHOT_HW     = 1,
  parameter int SHOT_HH     = 4,
  parameter int Y_MIN       = 0,
  parameter int COOLDOWN    = 4,
  parameter int FIRE_KEY    = 44,
  parameter int RESTART_KEY = 21
) (
  input logic frame_clk,
  input logic Reset,
  player_shot_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    FLYING,
    COOL
  } state_t;

  state_t           state;
  logic [9:0]       shot_x;
  logic [9:0]       shot_y;
  logic             active;
  logic [N_INV-1:0] coll;
  logic [7:0]       hit_cnt;
  logic [7:0]       cd_cnt;

  logic [N_INV-1:0] hit;
  logic [N_INV-1:0] hit_sel;
  logic             expire;
  logic             cd_done;
  logic             restart;

  // Boxes overlap when centre distance is strictly below the
  // summed half-sizes; 11-bit math keeps the sums from wrapping.
  always_comb begin
    logic [10:0] lim_x, lim_y, sx, sy, ix, iy, dx, dy;
    hit   = '0;
    lim_x = 11'(SHOT_HW) + {1'b0, bus.InvaderS};
    lim_y = 11'(SHOT_HH) + {1'b0, bus.InvaderS};
    sx    = {1'b0, shot_x};
    sy    = {1'b0, shot_y};
    for (int i = 0; i < N_INV; i++) begin
      ix = {1'b0, bus.InvaderX_all[10*i +: 10]};
      iy = {1'b0, bus.InvaderY_all[10*i +: 10]};
      dx = (sx >= ix) ? sx - ix : ix - sx;
      dy = (sy >= iy) ? sy - iy : iy - sy;
      hit[i] = bus.InvaderOn_all[i] && (dx < lim_x) && (dy < lim_y);
    end
  end

  assign hit_sel = hit & (~hit + 1'b1);
  assign expire  = {1'b0, shot_y} < 11'(Y_MIN + SHOT_STEP);
  assign cd_done = (COOLDOWN == 0) || (cd_cnt == 8'(COOLDOWN - 1));
  assign restart = Reset || (bus.keycode == 8'(RESTART_KEY));

  always_ff @(posedge frame_clk) begin
    if (restart) begin
      state   <= IDLE;
      shot_x  <= '0;
      shot_y  <= '0;
      active  <= 1'b0;
      coll    <= '0;
      hit_cnt <= '0;
      cd_cnt  <= '0;
    end else begin
      coll <= '0;
      case (state)
        IDLE: begin
          if (bus.keycode == 8'(FIRE_KEY)) begin
            state  <= FLYING;
            shot_x <= bus.PlayerX;
            shot_y <= bus.PlayerY;
            active <= 1'b1;
          end
        end
        FLYING: begin
          if (|hit) begin
            coll   <= hit_sel;
            active <= 1'b0;
            state  <= COOL;
            cd_cnt <= '0;
            if (hit_cnt != 8'hFF) hit_cnt <= hit_cnt + 8'd1;
          end else if (expire) begin
            active <= 1'b0;
            state  <= COOL;
            cd_cnt <= '0;
          end else begin
            shot_y <= shot_y - 10'(SHOT_STEP);
          end
        end
        COOL: begin
          if (cd_done) state <= IDLE;
          else cd_cnt <= cd_cnt + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ShotX      = shot_x;
  assign bus.ShotY      = shot_y;
  assign bus.ShotW      = 10'(SHOT_HW);
  assign bus.ShotH      = 10'(SHOT_HH);
  assign bus.ShotActive = active;
  assign bus.Collision  = coll;
  assign bus.HitCount   = hit_cnt;

endmodule

// File: tb/tb_player_shot.sv
// Directed bench for player_shot: flight, hits, priority,
// boundaries, restart and score saturation.
module tb_player_shot;

  logic frame_clk = 1'b0;
  logic Reset;
  int   total = 0;
  int   bad   = 0;

  player_shot_if #(.N_INV(10)) bus ();

  player_shot dut (
    .frame_clk(frame_clk),
    .Reset(Reset),
    .bus(bus)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_inv(input int i, input int x, input int y,
                         input logic on);
    bus.InvaderX_all[10*i +: 10] = 10'(x);
    bus.InvaderY_all[10*i +: 10] = 10'(y);
    bus.InvaderOn_all[i]         = on;
  endtask

  initial begin
    Reset = 1'b1;
    bus.keycode       = 8'd0;
    bus.PlayerX       = 10'd320;
    bus.PlayerY       = 10'd440;
    bus.InvaderS      = 10'd12;
    bus.InvaderX_all  = '0;
    bus.InvaderY_all  = '0;
    bus.InvaderOn_all = '0;
    tick();
    Reset = 1'b0;
    chk("rst_active", bus.ShotActive, 0);
    chk("rst_x", bus.ShotX, 0);
    chk("rst_y", bus.ShotY, 0);
    chk("rst_coll", bus.Collision, 0);
    chk("rst_hits", bus.HitCount, 0);
    chk("shot_w", bus.ShotW, 1);
    chk("shot_h", bus.ShotH, 4);

    // fire and fly to the top
    bus.keycode = 8'd44;
    tick();
    bus.keycode = 8'd0;
    chk("fire_active", bus.ShotActive, 1);
    chk("fire_x", bus.ShotX, 320);
    chk("fire_y", bus.ShotY, 440);
    for (int k = 2; k <= 56; k++) begin
      tick();
      chk("fly_y", bus.ShotY, 440 - 8 * (k - 1));
      chk("fly_coll", bus.Collision, 0);
    end
    chk("fly_active", bus.ShotActive, 1);
    tick();
    chk("exit_active", bus.ShotActive, 0);
    chk("exit_coll", bus.Collision, 0);

    // fire held through cooldown
    bus.keycode = 8'd44;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("cool_active", bus.ShotActive, 0);
    end
    tick();
    chk("refire_active", bus.ShotActive, 1);
    chk("refire_y", bus.ShotY, 440);

    // single hit on invader 3
    set_inv(3, 320, 200, 1'b1);
    for (int k = 0; k < 29; k++) begin
      tick();
      chk("approach_coll", bus.Collision, 0);
    end
    chk("approach_y", bus.ShotY, 208);
    tick();
    chk("hit3_coll", bus.Collision, 10'b0000001000);
    chk("hit3_active", bus.ShotActive, 0);
    chk("hit3_hits", bus.HitCount, 1);
    chk("hit3_y", bus.ShotY, 208);
    tick();
    chk("hit3_pulse", bus.Collision, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hold_active", bus.ShotActive, 0);
    end
    set_inv(3, 320, 200, 1'b0);
    set_inv(2, 320, 432, 1'b1);
    set_inv(5, 320, 432, 1'b1);
    tick();
    chk("held_fire", bus.ShotActive, 1);
    bus.keycode = 8'd0;

    // invaders 2 and 5 overlap together
    tick();
    chk("prio_coll", bus.Collision, 10'b0000000100);
    chk("prio_hits", bus.HitCount, 2);
    tick();
    chk("prio_pulse", bus.Collision, 0);
    repeat (3) tick();
    bus.InvaderOn_all = '0;
    set_inv(0, 320, 432, 1'b0);
    bus.keycode = 8'd44;
    tick();
    bus.keycode = 8'd0;
    chk("dead_fire", bus.ShotActive, 1);

    // dead invader, then dx=13 then dx=12
    tick();
    chk("dead_coll", bus.Collision, 0);
    chk("dead_y", bus.ShotY, 432);
    set_inv(0, 333, 432, 1'b1);
    tick();
    chk("dx13_coll", bus.Collision, 0);
    chk("dx13_y", bus.ShotY, 424);
    set_inv(0, 332, 424, 1'b1);
    tick();
    chk("dx12_coll", bus.Collision, 10'b0000000001);
    chk("dx12_hits", bus.HitCount, 3);

    // restart mid-flight
    repeat (4) tick();
    bus.InvaderOn_all = '0;
    bus.PlayerX = 10'd100;
    bus.PlayerY = 10'd300;
    bus.keycode = 8'd44;
    tick();
    chk("abort_fire_y", bus.ShotY, 300);
    chk("abort_fire_x", bus.ShotX, 100);
    bus.keycode = 8'd21;
    tick();
    chk("abort_active", bus.ShotActive, 0);
    chk("abort_x", bus.ShotX, 0);
    chk("abort_y", bus.ShotY, 0);
    chk("abort_coll", bus.Collision, 0);
    chk("abort_hits", bus.HitCount, 0);

    // saturation: invader parked on the spawn point
    bus.PlayerX = 10'd320;
    bus.PlayerY = 10'd440;
    set_inv(0, 320, 440, 1'b1);
    bus.keycode = 8'd44;
    tick();
    chk("sat_fire", bus.ShotActive, 1);
    tick();
    chk("sat_first", bus.HitCount, 1);
    chk("sat_first_coll", bus.Collision, 10'b0000000001);
    repeat (6 * 253) tick();
    chk("sat_254", bus.HitCount, 254);
    repeat (6) tick();
    chk("sat_255", bus.HitCount, 255);
    repeat (6 * 5) tick();
    chk("sat_260", bus.HitCount, 255);
    chk("sat_260_coll", bus.Collision, 10'b0000000001);

    // plain reset clears the score
    bus.keycode = 8'd0;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("final_hits", bus.HitCount, 0);
    chk("final_active", bus.ShotActive, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
